// File: rtl/assoc_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : assoc_data_cache
// Purpose  : Parametrised 1/2-way set-associative, write-through,
//            no-write-allocate data cache between the MEM stage and the
//            SRAM controller, with saturating load hit/miss counters.
// Revision : 1.0 - initial release
// ============================================================================
module assoc_data_cache #(
    parameter int SETS      = 64,
    parameter int WAYS      = 2,
    parameter int ADDR_BASE = 1024,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             MEM_R_EN,
    input  logic             MEM_W_EN,
    input  logic [31:0]      addr,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata,
    output logic             ready,
    input  logic             sram_ready,
    input  logic [63:0]      sram_rdata,
    output logic             sram_re,
    output logic             sram_we,
    output logic [31:0]      sram_addr,
    output logic [31:0]      sram_wdata,
    output logic [CNT_W-1:0] hit_count,
    output logic [CNT_W-1:0] miss_count
);

    localparam int SET_W = $clog2(SETS);
    localparam int TAG_W = 29 - SET_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FILL  = 2'd1,
        WRITE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Address decode, relative to the cacheable window base
    logic [31:0]      off;
    logic             word_sel;
    logic [SET_W-1:0] set_idx;
    logic [TAG_W-1:0] tag_in;
    logic [1:0]       unused_off;

    assign off        = addr - 32'(ADDR_BASE);
    assign word_sel   = off[2];
    assign set_idx    = off[2+SET_W:3];
    assign tag_in     = off[31:3+SET_W];
    assign unused_off = off[1:0];

    // Line storage
    logic             valid_q [WAYS][SETS];
    logic [TAG_W-1:0] tag_q   [WAYS][SETS];
    logic [31:0]      word0_q [WAYS][SETS];
    logic [31:0]      word1_q [WAYS][SETS];

    logic [WAYS-1:0]  way_hit;
    logic             hit;
    logic             hit_way;
    logic [31:0]      hit_word;
    logic             victim;

    // Control strobes from the FSM
    logic             fill_en;
    logic             store_en;
    logic             lru_we;
    logic             lru_val;
    logic             hit_inc;
    logic             miss_inc;

    // Tag compare across all ways and select the hitting word
    always_comb begin
        way_hit  = '0;
        hit_word = '0;
        for (int w = 0; w < WAYS; w++) begin
            way_hit[w] = valid_q[w][set_idx] && (tag_q[w][set_idx] == tag_in);
            if (way_hit[w]) begin
                hit_word = word_sel ? word1_q[w][set_idx] : word0_q[w][set_idx];
            end
        end
    end

    assign hit     = |way_hit;
    // Tags within a set are unique, so at most one way can hit
    assign hit_way = (WAYS == 2) ? way_hit[WAYS-1] : 1'b0;

    generate
        if (WAYS == 2) begin : g_lru
            logic lru_q [SETS];

            // LRU bit per set names the way to evict next
            always_ff @(posedge clk) begin
                if (rst) begin
                    for (int s = 0; s < SETS; s++) begin
                        lru_q[s] <= 1'b0;
                    end
                end else if (lru_we) begin
                    lru_q[set_idx] <= lru_val;
                end
            end

            // Fill an empty way first, otherwise evict the LRU way
            assign victim = !valid_q[0][set_idx] ? 1'b0 :
                            !valid_q[1][set_idx] ? 1'b1 : lru_q[set_idx];
        end else begin : g_direct
            logic unused_lru;
            assign victim     = 1'b0;
            assign unused_lru = lru_we ^ lru_val;
        end
    endgenerate

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d  = state_q;
        ready    = 1'b0;
        rdata    = '0;
        sram_re  = 1'b0;
        sram_we  = 1'b0;
        fill_en  = 1'b0;
        store_en = 1'b0;
        lru_we   = 1'b0;
        lru_val  = 1'b0;
        hit_inc  = 1'b0;
        miss_inc = 1'b0;
        case (state_q)
            IDLE: begin
                ready = 1'b1;
                if (MEM_W_EN) begin
                    // Stores win over a simultaneous load
                    ready   = 1'b0;
                    state_d = WRITE;
                end else if (MEM_R_EN) begin
                    if (hit) begin
                        rdata   = hit_word;
                        lru_we  = 1'b1;
                        lru_val = ~hit_way;
                        hit_inc = 1'b1;
                    end else begin
                        ready    = 1'b0;
                        miss_inc = 1'b1;
                        state_d  = FILL;
                    end
                end
            end
            FILL: begin
                sram_re = 1'b1;
                if (sram_ready) begin
                    fill_en = 1'b1;
                    lru_we  = 1'b1;
                    lru_val = ~victim;
                    ready   = 1'b1;
                    // Forward the requested word straight from the returned line
                    if (MEM_R_EN) begin
                        rdata = word_sel ? sram_rdata[63:32] : sram_rdata[31:0];
                    end
                    state_d = IDLE;
                end
            end
            WRITE: begin
                sram_we = 1'b1;
                if (sram_ready) begin
                    ready = 1'b1;
                    if (hit) begin
                        store_en = 1'b1;
                        lru_we   = 1'b1;
                        lru_val  = ~hit_way;
                    end
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    assign sram_addr  = addr;
    assign sram_wdata = wdata;

    // Valid bits: cleared by reset, set when a line is installed
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int w = 0; w < WAYS; w++) begin
                for (int s = 0; s < SETS; s++) begin
                    valid_q[w][s] <= 1'b0;
                end
            end
        end else if (fill_en) begin
            for (int w = 0; w < WAYS; w++) begin
                if (w == int'(victim)) begin
                    valid_q[w][set_idx] <= 1'b1;
                end
            end
        end
    end

    // Tag and data arrays: line install on fill, word update on store hit
    always_ff @(posedge clk) begin
        for (int w = 0; w < WAYS; w++) begin
            if (fill_en && (w == int'(victim))) begin
                tag_q[w][set_idx]   <= tag_in;
                word0_q[w][set_idx] <= sram_rdata[31:0];
                word1_q[w][set_idx] <= sram_rdata[63:32];
            end
            if (store_en && way_hit[w]) begin
                if (word_sel) begin
                    word1_q[w][set_idx] <= wdata;
                end else begin
                    word0_q[w][set_idx] <= wdata;
                end
            end
        end
    end

    // Saturating load hit/miss counters
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_count  <= '0;
            miss_count <= '0;
        end else begin
            if (hit_inc && (hit_count != '1)) begin
                hit_count <= hit_count + 1'b1;
            end
            if (miss_inc && (miss_count != '1)) begin
                miss_count <= miss_count + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_assoc_data_cache.sv
`default_nettype none
// ============================================================================
// Module   : tb_assoc_data_cache
// Purpose  : Directed self-checking bench for assoc_data_cache (2-way,
//            64 sets, narrow counters so saturation is reachable).
// Revision : 1.0 - initial release
// ============================================================================
module tb_assoc_data_cache;

    localparam int CW = 3;

    logic          clk = 1'b0;
    logic          rst;
    logic          MEM_R_EN, MEM_W_EN;
    logic [31:0]   addr, wdata, rdata;
    logic          ready;
    logic          sram_ready;
    logic [63:0]   sram_rdata;
    logic          sram_re, sram_we;
    logic [31:0]   sram_addr, sram_wdata;
    logic [CW-1:0] hit_count, miss_count;

    int n_cmp  = 0;
    int n_fail = 0;

    assoc_data_cache #(
        .SETS(64), .WAYS(2), .ADDR_BASE(1024), .CNT_W(CW)
    ) dut (
        .clk(clk), .rst(rst),
        .MEM_R_EN(MEM_R_EN), .MEM_W_EN(MEM_W_EN),
        .addr(addr), .wdata(wdata), .rdata(rdata), .ready(ready),
        .sram_ready(sram_ready), .sram_rdata(sram_rdata),
        .sram_re(sram_re), .sram_we(sram_we),
        .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .hit_count(hit_count), .miss_count(miss_count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one request, answer the controller after 'lat' strobe cycles,
    // and return what the cache presented in its ready cycle.
    task automatic run_txn(input logic st, input logic [31:0] a, input logic [31:0] wd,
                           input int lat, input logic [63:0] line,
                           output logic [31:0] rd, output int wait_cyc,
                           output logic used_sram, output logic ok, output int proto);
        int k;
        k = 0; wait_cyc = 0; used_sram = 1'b0; ok = 1'b0; rd = '0; proto = 0;
        MEM_R_EN = !st; MEM_W_EN = st; addr = a; wdata = wd;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (sram_re && sram_we) proto++;
            if ((sram_re || sram_we) && (sram_addr !== a)) proto++;
            if (sram_we && (sram_wdata !== wd)) proto++;
            if (sram_re || sram_we) begin
                used_sram = 1'b1;
                k++;
                if (k >= lat) begin
                    sram_ready = 1'b1;
                    sram_rdata = line;
                end
            end
            #1;
            if (ready) begin
                rd = rdata;
                ok = 1'b1;
                break;
            end
            wait_cyc++;
        end
        @(posedge clk); #1;
        sram_ready = 1'b0; sram_rdata = '0;
        MEM_R_EN = 1'b0; MEM_W_EN = 1'b0;
    endtask

    typedef struct {
        logic        st;
        logic [31:0] a;
        logic [31:0] wd;
        int          lat;
        logic [63:0] line;
        logic        exp_sram;
        logic [31:0] exp_rd;
        int          exp_h;
        int          exp_m;
        int          exp_wait;
    } vec_t;

    vec_t vt [13];

    initial begin
        logic [31:0] rd;
        int          wc, proto;
        logic        used, ok, saw_re, done;
        int          nwe;

        vt[0]  = '{1'b0, 32'd1024, 32'h0,        5, 64'h22222222_11111111, 1'b1, 32'h11111111, 0, 1, 5};
        vt[1]  = '{1'b0, 32'd1028, 32'h0,        1, 64'h0,                 1'b0, 32'h22222222, 1, 1, 0};
        vt[2]  = '{1'b0, 32'd1536, 32'h0,        2, 64'h44444444_33333333, 1'b1, 32'h33333333, 1, 2, 2};
        vt[3]  = '{1'b0, 32'd1024, 32'h0,        1, 64'h0,                 1'b0, 32'h11111111, 2, 2, 0};
        vt[4]  = '{1'b0, 32'd2048, 32'h0,        3, 64'h66666666_55555555, 1'b1, 32'h55555555, 2, 3, 3};
        vt[5]  = '{1'b0, 32'd1024, 32'h0,        1, 64'h0,                 1'b0, 32'h11111111, 3, 3, 0};
        vt[6]  = '{1'b0, 32'd1536, 32'h0,        1, 64'h44444444_33333333, 1'b1, 32'h33333333, 3, 4, 1};
        vt[7]  = '{1'b1, 32'd1028, 32'hDEADBEEF, 4, 64'h0,                 1'b1, 32'h0,        3, 4, 4};
        vt[8]  = '{1'b0, 32'd1028, 32'h0,        1, 64'h0,                 1'b0, 32'hDEADBEEF, 4, 4, 0};
        vt[9]  = '{1'b1, 32'd3072, 32'h12345678, 2, 64'h0,                 1'b1, 32'h0,        4, 4, 2};
        vt[10] = '{1'b0, 32'd3072, 32'h0,        2, 64'h88888888_77777777, 1'b1, 32'h77777777, 4, 5, 2};
        vt[11] = '{1'b0, 32'd1024, 32'h0,        1, 64'h0,                 1'b0, 32'h11111111, 5, 5, 0};
        vt[12] = '{1'b0, 32'd1028, 32'h0,        1, 64'h0,                 1'b0, 32'hDEADBEEF, 6, 5, 0};

        rst = 1'b1; MEM_R_EN = 1'b0; MEM_W_EN = 1'b0; addr = '0; wdata = '0;
        sram_ready = 1'b0; sram_rdata = '0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_ready", 64'(ready), 64'd1);
        check("reset_rdata", 64'(rdata), 64'd0);
        check("reset_strobes", 64'({sram_re, sram_we}), 64'd0);
        check("reset_counts", 64'({hit_count, miss_count}), 64'd0);
        @(posedge clk); #1;

        // Table-driven transactions
        for (int i = 0; i < 13; i++) begin
            run_txn(vt[i].st, vt[i].a, vt[i].wd, vt[i].lat, vt[i].line, rd, wc, used, ok, proto);
            check($sformatf("v%0d_done", i), 64'(ok), 64'd1);
            check($sformatf("v%0d_sram", i), 64'(used), 64'(vt[i].exp_sram));
            check($sformatf("v%0d_rdata", i), 64'(rd), 64'(vt[i].exp_rd));
            check($sformatf("v%0d_wait", i), 64'(wc), 64'(vt[i].exp_wait));
            check($sformatf("v%0d_proto", i), 64'(proto), 64'd0);
            @(negedge clk);
            check($sformatf("v%0d_hits", i), 64'(hit_count), 64'(vt[i].exp_h));
            check($sformatf("v%0d_miss", i), 64'(miss_count), 64'(vt[i].exp_m));
            @(posedge clk); #1;
        end

        // Load and store together: store first, then the held load hits
        MEM_R_EN = 1'b1; MEM_W_EN = 1'b1; addr = 32'd1024; wdata = 32'hCAFEF00D;
        saw_re = 1'b0; done = 1'b0; nwe = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (sram_re) saw_re = 1'b1;
            if (sram_we) begin
                nwe++;
                if (nwe == 2) sram_ready = 1'b1;
            end
            #1;
            if (ready) begin
                done = 1'b1;
                break;
            end
        end
        check("both_done", 64'(done), 64'd1);
        check("both_no_re", 64'(saw_re), 64'd0);
        check("both_we_seen", 64'(nwe), 64'd2);
        @(posedge clk); #1;
        sram_ready = 1'b0; MEM_W_EN = 1'b0;
        @(negedge clk);
        check("both_read_ready", 64'(ready), 64'd1);
        check("both_read_rdata", 64'(rdata), 64'hCAFEF00D);
        check("both_read_no_re", 64'(sram_re), 64'd0);
        @(posedge clk); #1;
        MEM_R_EN = 1'b0;
        @(negedge clk);
        check("both_hits", 64'(hit_count), 64'd7);

        // Reset two cycles into a fill, with sram_ready pending at that edge
        @(posedge clk); #1;
        MEM_R_EN = 1'b1; addr = 32'd2048;
        @(negedge clk);
        check("rstfill_idle_ready", 64'(ready), 64'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("rstfill_re", 64'(sram_re), 64'd1);
        @(posedge clk); #1;
        rst = 1'b1; sram_ready = 1'b1; sram_rdata = 64'hAAAAAAAA_99999999;
        @(posedge clk); #1;
        rst = 1'b0; sram_ready = 1'b0; sram_rdata = '0; MEM_R_EN = 1'b0;
        @(negedge clk);
        check("rstfill_re_drop", 64'(sram_re), 64'd0);
        check("rstfill_ready", 64'(ready), 64'd1);
        check("rstfill_counts", 64'({hit_count, miss_count}), 64'd0);
        @(posedge clk); #1;

        run_txn(1'b0, 32'd1024, 32'h0, 2, 64'h22222222_11111111, rd, wc, used, ok, proto);
        check("post_rst_1024_sram", 64'(used), 64'd1);
        check("post_rst_1024_rdata", 64'(rd), 64'h11111111);
        run_txn(1'b0, 32'd2048, 32'h0, 2, 64'hAAAAAAAA_99999999, rd, wc, used, ok, proto);
        check("post_rst_2048_sram", 64'(used), 64'd1);
        check("post_rst_2048_rdata", 64'(rd), 64'h99999999);
        @(negedge clk);
        check("post_rst_hits", 64'(hit_count), 64'd0);
        check("post_rst_miss", 64'(miss_count), 64'd2);

        // Hold a hitting load for many cycles: hit counter saturates
        @(posedge clk); #1;
        MEM_R_EN = 1'b1; addr = 32'd1024;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            check($sformatf("sat_ready_%0d", c), 64'(ready), 64'd1);
            @(posedge clk); #1;
        end
        MEM_R_EN = 1'b0;
        @(negedge clk);
        check("sat_hits", 64'(hit_count), 64'd7);
        check("sat_miss", 64'(miss_count), 64'd2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
